ctrl_decode_pipe: RTL and testbench
===================================

# ctrl_decode_pipe

- Parametrised, pipelined successor to the combinational ARM-subset instruction decoder.
- Decodes mode/opcode/S into execute command, memory, write-back, branch and status-update controls.
- Evaluates the 4-bit ARM condition field against NZCV, and carries the result through a STAGES-deep valid/ready pipeline with stall and flush.
- Sits between the IF/ID register and the EX stage, replacing the separate decoder plus ID/EX control register.

## Interface
Parameters:
- STAGES, 2, register depth from input to output (1..4)
- CMD_W, 4, width of exe_cmd
- CNT_W, 8, width of the illegal-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block accepts input this cycle
- mode  in  2  instruction mode field
- op_code  in  4  opcode field
- s_in  in  1  S bit (L bit for memory mode)
- cond  in  4  condition field
- status  in  4  NZCV flags {N,Z,C,V}, sampled on accept
- flush  in  1  discard all in-flight entries
- out_ready  in  1  EX stage accepts output
- out_valid  out  1  output entry valid
- exe_cmd  out  CMD_W  ALU command
- mem_read  out  1  load
- mem_write  out  1  store
- wb_en  out  1  register write-back
- branch  out  1  branch taken
- s_out  out  1  update status register
- cond_pass  out  1  condition evaluated true
- illegal  out  1  undefined encoding
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

## Operation

**Decode, mode 00.** Each opcode maps to an exe_cmd; wb_en=1 and s_out=s_in unless noted.
- MOV 1101 → 0001
- MVN 1111 → 1001
- ADD 0100 → 0010
- ADC 0101 → 0011
- SUB 0010 → 0100
- SBC 0110 → 0101
- AND 0000 → 0110
- ORR 1100 → 0111
- EOR 0001 → 1000
- CMP 1010 → 0100, wb_en=0, s_out=1
- TST 1000 → 0110, wb_en=0, s_out=1
- Any other opcode → all controls 0, illegal=1.

**Decode, modes 01–11.**
- Mode 01, s_in=1 (LDR): exe_cmd=0010, mem_read=1, wb_en=1, s_out=0.
- Mode 01, s_in=0 (STR): exe_cmd=0010, mem_write=1, s_out=0.
- Mode 10: branch=1, all other controls 0.
- Mode 11: all controls 0, illegal=1.

**Condition evaluation.**
- Codes 0000..1110: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, with standard ARM equations.
- Code 1111: never.
- If the condition fails: cond_pass=0; mem_read, mem_write, wb_en, branch and s_out are forced to 0; exe_cmd and illegal are kept.

**Pipeline.**
- Decode and condition evaluation are combinational on the inputs; the result is captured into stage 0 on accept (in_valid & in_ready).
- Each stage holds a valid bit plus the decoded controls.
- Stage i loads from stage i-1 when stage i is empty or advancing.
- The last stage advances when out_ready=1.
- in_ready = stage 0 empty or stage 0 advancing. Bubbles collapse.
- Outputs are driven directly from the last stage.
- When out_valid=0, all control outputs read 0.

**Flush.**
- Synchronous; has priority over everything.
- All valid bits clear at the next edge; input presented in the same cycle is dropped.
- illegal_cnt is not incremented by a dropped input.

**illegal_cnt.** Increments when an illegal instruction is accepted and not flushed. Saturates at 2^CNT_W-1.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits 0, all outputs 0, illegal_cnt=0. Reset mid-stream discards all entries.
- Latency: an instruction accepted at edge k appears with out_valid=1 after edge k+STAGES-1, provided out_ready=1 throughout.
- Throughput: 1 instruction per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, the outputs hold stable. Upstream stages fill, then in_ready drops.
- The status input is sampled only in the accept cycle; later flag changes do not affect in-flight entries.
- Simultaneous flush and out_ready: the output entry counts as consumed if out_valid was 1 in that cycle; the pipeline is empty the next cycle.
- STAGES=1: a single register; in_ready = ~out_valid | out_ready.

## Test plan
- Reset, then send ADD (mode 00, op 0100, s_in=1, cond 1110), STAGES=2, out_ready=1 → out_valid one cycle after the accept edge; exe_cmd=0010, wb_en=1, s_out=1, cond_pass=1.
- Send CMP, then LDR (mode 01, s_in=1), then STR (s_in=0), back-to-back → outputs in order:
  - CMP: exe_cmd=0100, wb_en=0, s_out=1
  - LDR: exe_cmd=0010, mem_read=1, wb_en=1, s_out=0
  - STR: exe_cmd=0010, mem_write=1
  - One per cycle, no gaps.
- Send ADD with cond 0000 (EQ) and status Z=0 → cond_pass=0, wb_en=0, exe_cmd=0010. Same instruction with Z=1 → cond_pass=1, wb_en=1.
- Hold out_ready=0 and stream 4 instructions with STAGES=2 → in_ready drops after 2 accepts and the held output stays stable. Release out_ready → all 4 emerge in order with no loss or duplication.
- Fill the pipe, assert flush for 1 cycle alongside a new input → out_valid=0 the next cycle; the dropped input never appears.
- Send 260 illegal instructions (mode 11), CNT_W=8 → illegal=1 on each output; illegal_cnt saturates at 255. Assert rst_n=0 mid-stream → illegal_cnt=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe
//   Pipelined ARM-subset instruction decoder. Turns mode/opcode/S into
//   execute, memory, write-back, branch and status-update controls. It also
//   evaluates the condition field against the NZCV flags sampled on accept.
//   The result is carried through a STAGES-deep valid/ready pipeline that
//   supports stall and flush.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   mode, op_code, s_in instruction fields (s_in is the L bit in memory mode)
//   cond, status        condition field and {N,Z,C,V} flags
//   flush               discard every in-flight entry and the current input
//   out_ready/out_valid downstream handshake
//   exe_cmd .. illegal  decoded controls from the last stage, zero when idle
//   illegal_cnt         saturating count of accepted illegal instructions

module ctrl_decode_pipe #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             s_in,
  input  logic [3:0]       cond,
  input  logic [3:0]       status,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_en,
  output logic             branch,
  output logic             s_out,
  output logic             cond_pass,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_UND = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_TST = 4'b1000,
    OP_CMP = 4'b1010,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_MVN = 4'b1111
  } op_e;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  typedef struct packed {
    logic [CMD_W-1:0] exe_cmd;
    logic             mem_read;
    logic             mem_write;
    logic             wb_en;
    logic             branch;
    logic             s_out;
    logic             cond_pass;
    logic             illegal;
  } ctrl_t;

  logic  n_f, z_f, c_f, v_f;
  logic  cond_ok;
  ctrl_t dec;

  assign {n_f, z_f, c_f, v_f} = status;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      CC_EQ:   cond_ok = z_f;
      CC_NE:   cond_ok = ~z_f;
      CC_CS:   cond_ok = c_f;
      CC_CC:   cond_ok = ~c_f;
      CC_MI:   cond_ok = n_f;
      CC_PL:   cond_ok = ~n_f;
      CC_VS:   cond_ok = v_f;
      CC_VC:   cond_ok = ~v_f;
      CC_HI:   cond_ok = c_f & ~z_f;
      CC_LS:   cond_ok = ~c_f | z_f;
      CC_GE:   cond_ok = (n_f == v_f);
      CC_LT:   cond_ok = (n_f != v_f);
      CC_GT:   cond_ok = ~z_f & (n_f == v_f);
      CC_LE:   cond_ok = z_f | (n_f != v_f);
      CC_AL:   cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec = '0;
    case (mode)
      MODE_DP: begin
        dec.wb_en = 1'b1;
        dec.s_out = s_in;
        case (op_code)
          OP_MOV:  dec.exe_cmd = CMD_W'(4'b0001);
          OP_MVN:  dec.exe_cmd = CMD_W'(4'b1001);
          OP_ADD:  dec.exe_cmd = CMD_W'(4'b0010);
          OP_ADC:  dec.exe_cmd = CMD_W'(4'b0011);
          OP_SUB:  dec.exe_cmd = CMD_W'(4'b0100);
          OP_SBC:  dec.exe_cmd = CMD_W'(4'b0101);
          OP_AND:  dec.exe_cmd = CMD_W'(4'b0110);
          OP_ORR:  dec.exe_cmd = CMD_W'(4'b0111);
          OP_EOR:  dec.exe_cmd = CMD_W'(4'b1000);
          OP_CMP: begin
            dec.exe_cmd = CMD_W'(4'b0100);
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b1;
          end
          OP_TST: begin
            dec.exe_cmd = CMD_W'(4'b0110);
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b1;
          end
          default: begin
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      MODE_MEM: begin
        dec.exe_cmd   = CMD_W'(4'b0010);
        dec.mem_read  = s_in;
        dec.mem_write = ~s_in;
        dec.wb_en     = s_in;
      end
      MODE_BR:  dec.branch  = 1'b1;
      default:  dec.illegal = 1'b1;
    endcase

    // A failed condition suppresses side effects but keeps exe_cmd/illegal.
    dec.cond_pass = cond_ok;
    if (!cond_ok) begin
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.wb_en     = 1'b0;
      dec.branch    = 1'b0;
      dec.s_out     = 1'b0;
    end
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  ctrl_t             stg [STAGES];
  ctrl_t             out_c;
  logic              accept;

  // Stage k may load when any stage at or beyond k has a hole, or the last
  // stage drains. Computing it from the valid vector directly avoids a
  // combinational chain through ld itself.
  always_comb begin
    ld = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      ld[k] = out_ready | (|((~vld) >> k));
    end
  end

  assign in_ready = ld[0];
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        stg[k] <= '0;
      end
    end else begin
      if (flush) begin
        vld <= '0;
      end else begin
        if (ld[0]) vld[0] <= in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
          if (ld[k]) vld[k] <= vld[k-1];
        end
      end
      if (ld[0] && in_valid) stg[0] <= dec;
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (ld[k] && vld[k-1]) stg[k] <= stg[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && dec.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_c     = out_valid ? stg[STAGES-1] : '0;
  assign exe_cmd   = out_c.exe_cmd;
  assign mem_read  = out_c.mem_read;
  assign mem_write = out_c.mem_write;
  assign wb_en     = out_c.wb_en;
  assign branch    = out_c.branch;
  assign s_out     = out_c.s_out;
  assign cond_pass = out_c.cond_pass;
  assign illegal   = out_c.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe (STAGES=2, CMD_W=4, CNT_W=8).
// Accepted instructions are modelled and queued; outputs are compared
// against the queue head when the EX side consumes them.

module tb_ctrl_decode_pipe;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [3:0]       op_code;
  logic             s_in;
  logic [3:0]       cond;
  logic [3:0]       status;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [CMD_W-1:0] exe_cmd;
  logic             mem_read, mem_write, wb_en, branch, s_out, cond_pass, illegal;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.STAGES(STAGES), .CMD_W(CMD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .op_code(op_code), .s_in(s_in), .cond(cond), .status(status),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
    .wb_en(wb_en), .branch(branch), .s_out(s_out), .cond_pass(cond_pass),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  // {exe_cmd, mem_read, mem_write, wb_en, branch, s_out, cond_pass, illegal}
  typedef logic [10:0] bundle_t;

  bundle_t          obs;
  bundle_t          sb [$];
  bundle_t          acc_b;
  bundle_t          exp_b;
  logic [CNT_W-1:0] exp_cnt = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  assign obs = {exe_cmd, mem_read, mem_write, wb_en, branch, s_out, cond_pass, illegal};

  function automatic bundle_t model(input logic [1:0] m, input logic [3:0] op,
                                    input logic s, input logic [3:0] c,
                                    input logic [3:0] st);
    logic n, z, cf, v, base, pass;
    logic [3:0] cmd;
    logic rd, wr, wb, br, so, ill;
    {n, z, cf, v} = st;
    cmd = 4'b0000; rd = 0; wr = 0; wb = 0; br = 0; so = 0; ill = 0;
    case (m)
      2'b00: case (op)
        4'b1101: {cmd, wb, so} = {4'b0001, 1'b1, s};
        4'b1111: {cmd, wb, so} = {4'b1001, 1'b1, s};
        4'b0100: {cmd, wb, so} = {4'b0010, 1'b1, s};
        4'b0101: {cmd, wb, so} = {4'b0011, 1'b1, s};
        4'b0010: {cmd, wb, so} = {4'b0100, 1'b1, s};
        4'b0110: {cmd, wb, so} = {4'b0101, 1'b1, s};
        4'b0000: {cmd, wb, so} = {4'b0110, 1'b1, s};
        4'b1100: {cmd, wb, so} = {4'b0111, 1'b1, s};
        4'b0001: {cmd, wb, so} = {4'b1000, 1'b1, s};
        4'b1010: {cmd, wb, so} = {4'b0100, 1'b0, 1'b1};
        4'b1000: {cmd, wb, so} = {4'b0110, 1'b0, 1'b1};
        default: ill = 1;
      endcase
      2'b01: begin cmd = 4'b0010; rd = s; wr = !s; wb = s; end
      2'b10: br = 1;
      default: ill = 1;
    endcase
    // ARM pairs: odd codes are the inverse of the even code below them.
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1;
    endcase
    pass = base ^ c[0];
    if (!pass) {rd, wr, wb, br, so} = 5'b0;
    return {cmd, rd, wr, wb, br, so, pass, ill};
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready && !flush) begin
      acc_b = model(mode, op_code, s_in, cond, status);
      sb.push_back(acc_b);
      if (acc_b[0] && exp_cnt != '1) exp_cnt++;
    end
  end

  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
                       input logic s, input logic [3:0] c, input logic [3:0] st);
    in_valid = v; mode = m; op_code = op; s_in = s; cond = c; status = st;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 1; flush = 0;
    drive(0, 2'b00, 4'b0000, 0, 4'b1110, 4'b0000);
    #3;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 000", obs); end
    n_checks++; if (illegal_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", illegal_cnt); end
    sb.delete(); exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    drive(1, 2'b00, 4'b0100, 1, 4'b1110, 4'b0000);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1; idle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_early: got %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: got %b expected 1", out_valid); end
    n_checks++; if (obs !== 11'b0010_0_0_1_0_1_1_0) begin n_fail++; $display("FAIL add_fields: got %h expected %h", obs, 11'b0010_0_0_1_0_1_1_0); end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL add_sb: got %h expected none queued", obs); end
    else begin exp_b = sb.pop_front(); if (obs !== exp_b) begin n_fail++; $display("FAIL add_sb: got %h expected %h", obs, exp_b); end end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bundle_t ref_tab [3];
    int n_out = 0, first = -1, last = -1;
    ref_tab[0] = 11'b0100_0_0_0_0_1_1_0;  // CMP
    ref_tab[1] = 11'b0010_1_0_1_0_0_1_0;  // LDR
    ref_tab[2] = 11'b0010_0_1_0_0_0_1_0;  // STR
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive(1, 2'b00, 4'b1010, 0, 4'b1110, 4'b0000);
        1: drive(1, 2'b01, 4'b0000, 1, 4'b1110, 4'b0000);
        2: drive(1, 2'b01, 4'b0000, 0, 4'b1110, 4'b0000);
        default: idle();
      endcase
      @(negedge clk);
      if (c < 3) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1 at %0d", in_ready, c); end
      end
      if (out_valid && out_ready) begin
        if (first < 0) first = c;
        last = c;
        n_checks++;
        if (n_out < 3 && obs !== ref_tab[n_out]) begin n_fail++; $display("FAIL b2b_fields: got %h expected %h", obs, ref_tab[n_out]); end
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_sb: got %h expected none queued", obs); end
        else begin exp_b = sb.pop_front(); if (obs !== exp_b) begin n_fail++; $display("FAIL b2b_sb: got %h expected %h", obs, exp_b); end end
        n_out++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (n_out != 3 || first != 2 || last != 4) begin n_fail++; $display("FAIL b2b_timing: got n=%0d first=%0d last=%0d expected n=3 first=2 last=4", n_out, first, last); end
  endtask

  task automatic test_cond();
    bundle_t ref_tab [2];
    int n_out = 0;
    localparam int N = 2 + 64;
    ref_tab[0] = 11'b0010_0_0_0_0_0_0_0;  // ADD EQ, Z=0
    ref_tab[1] = 11'b0010_0_0_1_0_1_1_0;  // ADD EQ, Z=1
    for (int c = 0; c < N + 6; c++) begin
      if (c == 0) drive(1, 2'b00, 4'b0100, 1, 4'b0000, 4'b0000);
      else if (c == 1) drive(1, 2'b00, 4'b0100, 1, 4'b0000, 4'b0100);
      else if (c < N) drive(1, 2'(($urandom_range(3, 0) == 0) ? 0 : $urandom_range(2, 0)),
                            4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                            4'((c - 2) / 4), 4'($urandom_range(15, 0)));
      else idle();
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n_out < 2) begin
          n_checks++; if (obs !== ref_tab[n_out]) begin n_fail++; $display("FAIL cond_eq: got %h expected %h", obs, ref_tab[n_out]); end
        end
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL cond_sb: got %h expected none queued", obs); end
        else begin exp_b = sb.pop_front(); if (obs !== exp_b) begin n_fail++; $display("FAIL cond_sb: got %h expected %h", obs, exp_b); end end
        n_out++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (n_out != N) begin n_fail++; $display("FAIL cond_count: got %0d expected %0d", n_out, N); end
  endtask

  task automatic test_backpressure();
    logic [3:0] ops [4];
    bundle_t    held = '0;
    logic       have = 0;
    int         idx = 0, n_out = 0;
    ops[0] = 4'b0100; ops[1] = 4'b0010; ops[2] = 4'b1100; ops[3] = 4'b0001;
    out_ready = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, 2'b00, ops[idx], 1'(c), 4'b1110, 4'b0000);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        if (!have) begin held = obs; have = 1; end
        else begin
          n_checks++; if (obs !== held) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", obs, held); end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", idx); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (idx < 4) drive(1, 2'b00, ops[idx], 1'(idx), 4'b1110, 4'b0000);
      else idle();
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL bp_sb: got %h expected none queued", obs); end
        else begin exp_b = sb.pop_front(); if (obs !== exp_b) begin n_fail++; $display("FAIL bp_sb: got %h expected %h", obs, exp_b); end end
        n_out++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (n_out != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", n_out); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1, 2'b00, 4'b1101, 0, 4'b1110, 4'b0000);
    @(posedge clk); #1;
    drive(1, 2'b00, 4'b1111, 0, 4'b1110, 4'b0000);
    @(posedge clk); #1;
    drive(1, 2'b11, 4'b0000, 0, 4'b1110, 4'b0000);
    flush = 1; out_ready = 1;
    @(negedge clk);
    n_checks++;
    if (!out_valid || sb.size() == 0) begin n_fail++; $display("FAIL flush_head: got valid=%b expected 1", out_valid); end
    else begin exp_b = sb.pop_front(); if (obs !== exp_b) begin n_fail++; $display("FAIL flush_head: got %h expected %h", obs, exp_b); end end
    sb.delete();
    @(posedge clk); #1; idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b expected 0 (obs %h)", out_valid, obs); end
    end
    @(posedge clk); #1;
    n_checks++; if (illegal_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt: got %0d expected %0d", illegal_cnt, exp_cnt); end
  endtask

  task automatic test_illegal_sat();
    out_ready = 1;
    for (int c = 0; c < 266; c++) begin
      drive(1, 2'b11, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
            4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b expected 1", illegal); end
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL ill_sb: got %h expected none queued", obs); end
        else begin exp_b = sb.pop_front(); if (obs !== exp_b) begin n_fail++; $display("FAIL ill_sb: got %h expected %h", obs, exp_b); end end
      end
      @(posedge clk); #1;
      n_checks++; if (illegal_cnt !== exp_cnt) begin n_fail++; $display("FAIL ill_cnt: got %0d expected %0d", illegal_cnt, exp_cnt); end
    end
    n_checks++; if (illegal_cnt !== 8'd255) begin n_fail++; $display("FAIL ill_sat: got %0d expected 255", illegal_cnt); end
    #2 rst_n = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_rst_valid: got %b expected 0", out_valid); end
    n_checks++; if (illegal_cnt !== '0) begin n_fail++; $display("FAIL ill_rst_cnt: got %0d expected 0", illegal_cnt); end
    sb.delete(); exp_cnt = '0;
    idle();
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_after_rst: got %b expected 0", out_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 220; c++) begin
      if (c < 200) begin
        drive(1'($urandom_range(9, 0) < 7), 2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
              1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
        out_ready = ($urandom_range(9, 0) < 7);
        flush = ($urandom_range(19, 0) == 0);
      end else begin
        idle(); out_ready = 1;
      end
      @(negedge clk);
      if (!out_valid) begin
        n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL rand_idle_zero: got %h expected 000", obs); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rand_sb: got %h expected none queued", obs); end
        else begin exp_b = sb.pop_front(); if (obs !== exp_b) begin n_fail++; $display("FAIL rand_sb: got %h expected %h", obs, exp_b); end end
      end
      if (flush) sb.delete();
      @(posedge clk); #1;
      n_checks++; if (illegal_cnt !== exp_cnt) begin n_fail++; $display("FAIL rand_cnt: got %0d expected %0d", illegal_cnt, exp_cnt); end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d queued expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_cond();
    test_backpressure();
    test_flush();
    test_illegal_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
